// File: rtl/axis_eth_pkt_gen_pkg.sv
// -----------------------------------------------------------------------------
// axis_eth_pkt_gen_pkg
// Shared types and helpers for the AXI-Stream Ethernet frame generator.
//   ETH_HDR_BYTES  : length of the programmable Ethernet header (dst, src, type)
//   MAX_DATA_BYTES : widest beat the beat builder can produce
//   state_e        : generator FSM states
//   beat_t         : one beat at maximum width (data, keep, last)
//   build_beat     : builds the beat that starts at a given wire-byte offset
// -----------------------------------------------------------------------------
package axis_eth_pkt_gen_pkg;

    localparam int ETH_HDR_BYTES  = 14;
    localparam int MAX_DATA_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_e;

    typedef struct packed {
        logic [8*MAX_DATA_BYTES-1:0] data;
        logic [MAX_DATA_BYTES-1:0]   keep;
        logic                        last;
    } beat_t;

    // Beat starting at wire byte byte_offset of a frame of len bytes.
    // header is {dst, src, ethertype}; wire byte 0 sits in the top byte.
    // Only the low byte of the frame index matters for the payload pattern.
    // Lanes at or beyond data_bytes, and bytes past the frame end, stay zero.
    function automatic beat_t build_beat(input logic [31:0]  byte_offset,
                                         input logic [31:0]  len,
                                         input logic [7:0]   idx,
                                         input logic [111:0] header,
                                         input int           data_bytes);
        beat_t       b;
        logic [31:0] n;
        b = '0;
        for (int k = 0; k < MAX_DATA_BYTES; k++) begin
            n = byte_offset + 32'(k);
            if ((k < data_bytes) && (n < len)) begin
                b.keep[k] = 1'b1;
                if (n < 32'(ETH_HDR_BYTES)) begin
                    b.data[8*k +: 8] = header[8*(ETH_HDR_BYTES-1-int'(n)) +: 8];
                end else begin
                    b.data[8*k +: 8] = idx + n[7:0] - 8'(ETH_HDR_BYTES);
                end
            end
        end
        b.last = ((byte_offset + 32'(data_bytes)) >= len);
        return b;
    endfunction

endpackage

// File: rtl/axis_eth_pkt_gen_if.sv
// -----------------------------------------------------------------------------
// axis_eth_pkt_gen_if
// AXI-Stream bus carrying generated Ethernet frames.
//   tdata  : 8*DATA_BYTES, lane k = tdata[8k+:8], lane 0 is the earliest byte
//   tkeep  : DATA_BYTES, contiguous from lane 0
//   tlast  : last beat of a frame
//   tvalid : beat valid
//   tready : sink ready
// master = frame source, slave = frame sink.
// -----------------------------------------------------------------------------
interface axis_eth_pkt_gen_if #(
    parameter int DATA_BYTES = 1
);
    logic [8*DATA_BYTES-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// axis_eth_pkt_gen
// Deterministic AXI-Stream Ethernet frame transmitter. Each frame carries a
// programmable 14-byte header followed by a counting payload; the frame
// length sweeps over [max(min,14), max(max,lo)] and a programmable idle gap
// follows each frame.
// Ports:
//   clk, aresetn      : clock, asynchronous active-low reset
//   start / stop      : single-cycle run control pulses
//   cfg_*             : header, length range, frame count (0 = unlimited), gap;
//                       captured on start
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   pkt_count         : frames completed since the last start (wraps)
//   m_axis            : AXI-Stream master (tdata/tkeep/tlast/tvalid/tready)
// -----------------------------------------------------------------------------
module axis_eth_pkt_gen
    import axis_eth_pkt_gen_pkg::*;
#(
    parameter int DATA_BYTES = 1,
    parameter int LEN_W      = 16,
    parameter int GAP_W      = 8
) (
    input  logic                      clk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic                      stop,
    input  logic [47:0]               cfg_dst_mac,
    input  logic [47:0]               cfg_src_mac,
    input  logic [15:0]               cfg_ethertype,
    input  logic [LEN_W-1:0]          cfg_min_len,
    input  logic [LEN_W-1:0]          cfg_max_len,
    input  logic [LEN_W-1:0]          cfg_num_pkts,
    input  logic [GAP_W-1:0]          cfg_gap,
    output logic                      busy,
    output logic                      done,
    output logic [LEN_W-1:0]          pkt_count,
    axis_eth_pkt_gen_if.master        m_axis
);

    // Run state
    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    // Frames completed; also serves as the frame index i, since both clear on
    // start and advance on every accepted tlast.
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    stop_pend_q, stop_pend_d;

    // Captured configuration
    logic [111:0]            hdr_q, hdr_d;
    logic [LEN_W-1:0]        lo_q, lo_d;
    logic [LEN_W-1:0]        span_q, span_d;      // hi - lo
    logic [LEN_W-1:0]        num_q, num_d;
    logic [GAP_W-1:0]        gap_cfg_q, gap_cfg_d;

    // Frame progress
    logic [LEN_W-1:0]        len_off_q, len_off_d; // i mod (span + 1)
    logic [LEN_W-1:0]        off_q, off_d;         // wire offset of current beat
    logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;

    // Output beat register
    logic [8*DATA_BYTES-1:0] tdata_q, tdata_d;
    logic [DATA_BYTES-1:0]   tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;

    // Beat builder arguments and result
    logic [31:0]             bb_off, bb_len;
    logic [7:0]              bb_idx;
    logic [111:0]            bb_hdr;
    logic                    load_beat, clear_beat;
    beat_t                   nb;
    logic [8*DATA_BYTES-1:0] nb_data;
    logic [DATA_BYTES-1:0]   nb_keep;
    logic                    unused_beat_bits;

    logic [LEN_W-1:0]        lo_new, hi_new, cur_len, nxt_len_off;
    logic                    accept, stop_now, last_frame;

    // ---------------------------------------------------------------- control
    always_comb begin
        lo_new      = (cfg_min_len < LEN_W'(ETH_HDR_BYTES)) ? LEN_W'(ETH_HDR_BYTES) : cfg_min_len;
        hi_new      = (cfg_max_len < lo_new) ? lo_new : cfg_max_len;
        cur_len     = lo_q + len_off_q;
        // Wrapping counter replaces i mod (hi - lo + 1).
        nxt_len_off = (len_off_q == span_q) ? '0 : len_off_q + LEN_W'(1);
        accept      = tvalid_q && m_axis.tready;
        stop_now    = stop || stop_pend_q;
        last_frame  = (num_q != '0) && (cnt_q == num_q - LEN_W'(1));

        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        stop_pend_d = stop_pend_q;
        hdr_d       = hdr_q;
        lo_d        = lo_q;
        span_d      = span_q;
        num_d       = num_q;
        gap_cfg_d   = gap_cfg_q;
        len_off_d   = len_off_q;
        off_d       = off_q;
        gap_cnt_d   = gap_cnt_q;

        bb_off      = '0;
        bb_len      = 32'(cur_len);
        bb_idx      = cnt_q[7:0];
        bb_hdr      = hdr_q;
        load_beat   = 1'b0;
        clear_beat  = 1'b0;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    hdr_d     = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
                    lo_d      = lo_new;
                    span_d    = hi_new - lo_new;
                    num_d     = cfg_num_pkts;
                    gap_cfg_d = cfg_gap;
                    cnt_d     = '0;
                    len_off_d = '0;
                    off_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SEND;
                    bb_hdr    = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
                    bb_len    = 32'(lo_new);
                    bb_idx    = '0;
                    load_beat = 1'b1;
                end
            end
            SEND: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (accept) begin
                    if (!tlast_q) begin
                        off_d     = off_q + LEN_W'(DATA_BYTES);
                        bb_off    = 32'(off_q) + 32'(DATA_BYTES);
                        load_beat = 1'b1;
                    end else begin
                        cnt_d     = cnt_q + LEN_W'(1);
                        len_off_d = nxt_len_off;
                        off_d     = '0;
                        if (last_frame || stop_now) begin
                            state_d     = IDLE;
                            busy_d      = 1'b0;
                            done_d      = 1'b1;
                            stop_pend_d = 1'b0;
                            clear_beat  = 1'b1;
                        end else if (gap_cfg_q != '0) begin
                            state_d    = GAP;
                            gap_cnt_d  = gap_cfg_q;
                            clear_beat = 1'b1;
                        end else begin
                            // Back-to-back: preload the next frame's first beat.
                            bb_len    = 32'(lo_q + nxt_len_off);
                            bb_idx    = cnt_q[7:0] + 8'd1;
                            load_beat = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (stop_now) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    stop_pend_d = 1'b0;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    // Counters were advanced at the tlast, so defaults describe
                    // the next frame.
                    state_d   = SEND;
                    load_beat = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign nb               = build_beat(bb_off, bb_len, bb_idx, bb_hdr, DATA_BYTES);
    assign unused_beat_bits = ^nb;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BYTES; gi++) begin : g_lane
            assign nb_data[8*gi +: 8] = nb.data[8*gi +: 8];
            assign nb_keep[gi]        = nb.keep[gi];
        end
    endgenerate

    // Output beat register: load a new beat, clear when idling, else hold
    // (which keeps the beat stable while the sink stalls).
    always_comb begin
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        if (load_beat) begin
            tdata_d  = nb_data;
            tkeep_d  = nb_keep;
            tlast_d  = nb.last;
            tvalid_d = 1'b1;
        end else if (clear_beat) begin
            tdata_d  = '0;
            tkeep_d  = '0;
            tlast_d  = 1'b0;
            tvalid_d = 1'b0;
        end
    end

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            stop_pend_q <= 1'b0;
            hdr_q       <= '0;
            lo_q        <= '0;
            span_q      <= '0;
            num_q       <= '0;
            gap_cfg_q   <= '0;
            len_off_q   <= '0;
            off_q       <= '0;
            gap_cnt_q   <= '0;
            tdata_q     <= '0;
            tkeep_q     <= '0;
            tlast_q     <= 1'b0;
            tvalid_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            stop_pend_q <= stop_pend_d;
            hdr_q       <= hdr_d;
            lo_q        <= lo_d;
            span_q      <= span_d;
            num_q       <= num_d;
            gap_cfg_q   <= gap_cfg_d;
            len_off_q   <= len_off_d;
            off_q       <= off_d;
            gap_cnt_q   <= gap_cnt_d;
            tdata_q     <= tdata_d;
            tkeep_q     <= tkeep_d;
            tlast_q     <= tlast_d;
            tvalid_q    <= tvalid_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pkt_count     = cnt_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_eth_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_axis_eth_pkt_gen
// Two generator instances (1-byte and 8-byte beats) share configuration,
// stop, reset and tready; each has its own start. Expected beats are built by
// an independent frame model and queued per instance; a negedge monitor per
// instance pops and compares accepted beats and checks gaps and stall holds.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_eth_pkt_gen;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } exp_beat_t;

    typedef struct {
        int          sel;       // 0: 1-byte beats, 1: 8-byte beats
        int          min_len;
        int          max_len;
        int          num;
        int          gap;
        int          rmode;     // 0 always ready, 1 random ready
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        int          exp_cnt;   // expected pkt_count at done
    } vec_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic [47:0] cfg_dst_mac = '0;
    logic [47:0] cfg_src_mac = '0;
    logic [15:0] cfg_ethertype = '0;
    logic [15:0] cfg_min_len = '0;
    logic [15:0] cfg_max_len = '0;
    logic [15:0] cfg_num_pkts = '0;
    logic [7:0]  cfg_gap = '0;
    logic [1:0]  busy_w, done_w, tvalid_w, tlast_w;
    logic [15:0] cnt_w [2];
    logic        tready = 1'b1;
    int          ready_mode = 0;     // 0 ready, 1 random, 2 held low
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int DB = (gi == 0) ? 1 : 8;
            axis_eth_pkt_gen_if #(.DATA_BYTES(DB)) bus ();
            assign bus.tready   = tready;
            assign tvalid_w[gi] = bus.tvalid;
            assign tlast_w[gi]  = bus.tlast;

            axis_eth_pkt_gen #(.DATA_BYTES(DB), .LEN_W(16), .GAP_W(8)) dut (
                .clk           (clk),
                .aresetn       (aresetn),
                .start         (start_v[gi]),
                .stop          (stop),
                .cfg_dst_mac   (cfg_dst_mac),
                .cfg_src_mac   (cfg_src_mac),
                .cfg_ethertype (cfg_ethertype),
                .cfg_min_len   (cfg_min_len),
                .cfg_max_len   (cfg_max_len),
                .cfg_num_pkts  (cfg_num_pkts),
                .cfg_gap       (cfg_gap),
                .busy          (busy_w[gi]),
                .done          (done_w[gi]),
                .pkt_count     (cnt_w[gi]),
                .m_axis        (bus)
            );

            exp_beat_t exp_q[$];
            int        frames_acc = 0;
            int        last_acc_cyc = 0;
            int        gap_run = 0;
            bit        in_gap = 0;
            bit        mid = 0;
            bit        stalled = 0;
            exp_beat_t held;

            always @(negedge clk) begin
                exp_beat_t cur, e;
                cur.data = 64'(bus.tdata);
                cur.keep = 8'(bus.tkeep);
                cur.last = bus.tlast;
                if (!aresetn) begin
                    in_gap = 0; mid = 0; stalled = 0;
                end else begin
                    if (stalled) chk($sformatf("stall_hold_%0d", DB), 128'({bus.tvalid, cur}), 128'({1'b1, held}));
                    if (bus.tvalid) begin
                        if (in_gap) begin
                            chk($sformatf("gap_len_%0d", DB), 128'(gap_run), 128'(cfg_gap));
                            in_gap = 0;
                        end
                        if (tready) begin
                            chk($sformatf("beat_expected_%0d", DB), 128'(exp_q.size() != 0), 128'(1));
                            if (exp_q.size() != 0) begin
                                e = exp_q.pop_front();
                                chk($sformatf("beat_%0d_frame%0d", DB, frames_acc), 128'(cur), 128'(e));
                            end
                            if (cur.last) begin
                                frames_acc++; last_acc_cyc = cyc; in_gap = 1; gap_run = 0; mid = 0;
                            end else begin
                                mid = 1;
                            end
                            stalled = 0;
                        end else begin
                            stalled = 1; held = cur;
                        end
                    end else begin
                        if (mid) chk($sformatf("tvalid_mid_frame_%0d", DB), 128'(bus.tvalid), 128'(1));
                        if (in_gap) gap_run++;
                        stalled = 0;
                    end
                    if (!busy_w[gi]) begin in_gap = 0; mid = 0; end
                end
            end
        end
    endgenerate

    // Sink ready pattern, changed just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       tready = 1'b1;
            1:       tready = 1'($urandom_range(0, 1));
            default: tready = 1'b0;
        endcase
    end

    function automatic int qsize(input int sel);
        return (sel == 0) ? g_dut[0].exp_q.size() : g_dut[1].exp_q.size();
    endfunction
    function automatic int frames_of(input int sel);
        return (sel == 0) ? g_dut[0].frames_acc : g_dut[1].frames_acc;
    endfunction
    function automatic int last_acc_of(input int sel);
        return (sel == 0) ? g_dut[0].last_acc_cyc : g_dut[1].last_acc_cyc;
    endfunction

    // Reference frame model: header bytes then (i + n - 14) mod 256.
    task automatic push_frames(input int sel, input int minl, input int maxl, input int first_i,
                               input int nframes, input logic [47:0] dst, input logic [47:0] src,
                               input logic [15:0] et);
        int lo, hi, db, i, len, n;
        logic [7:0] hb [14];
        exp_beat_t b;
        lo = (minl < 14) ? 14 : minl;
        hi = (maxl < lo) ? lo : maxl;
        db = (sel == 0) ? 1 : 8;
        for (int k = 0; k < 6; k++) begin
            hb[k]     = dst[47-8*k -: 8];
            hb[6 + k] = src[47-8*k -: 8];
        end
        hb[12] = et[15:8];
        hb[13] = et[7:0];
        for (int f = 0; f < nframes; f++) begin
            i = first_i + f;
            len = lo + (i % (hi - lo + 1));
            for (int off = 0; off < len; off += db) begin
                b = '0;
                for (int k = 0; k < db; k++) begin
                    n = off + k;
                    if (n < len) begin
                        b.keep[k] = 1'b1;
                        b.data[8*k +: 8] = (n < 14) ? hb[n] : 8'((i + n - 14) % 256);
                    end
                end
                b.last = (off + db >= len);
                if (sel == 0) g_dut[0].exp_q.push_back(b);
                else          g_dut[1].exp_q.push_back(b);
            end
        end
    endtask

    task automatic set_cfg(input int minl, input int maxl, input int num, input int gap,
                           input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
        cfg_min_len = 16'(minl); cfg_max_len = 16'(maxl); cfg_num_pkts = 16'(num);
        cfg_gap = 8'(gap); cfg_dst_mac = dst; cfg_src_mac = src; cfg_ethertype = et;
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk); start_v[sel] = 1'b1;
        @(negedge clk); start_v[sel] = 1'b0;
        chk("busy_after_start", 128'(busy_w[sel]), 128'(1));
        chk("tvalid_after_start", 128'(tvalid_w[sel]), 128'(1));
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_done(input int sel, input int limit);
        bit ok = 0;
        for (int c = 0; c < limit; c++) begin
            if (done_w[sel]) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("done_seen", 128'(ok), 128'(1));
    endtask

    // Checks after done: count, busy low, queue drained, done timing, pulse width.
    task automatic end_checks(input int sel, input int exp_cnt, input bit timing);
        chk("pkt_count", 128'(cnt_w[sel]), 128'(exp_cnt));
        chk("busy_low_at_done", 128'(busy_w[sel]), 128'(0));
        chk("queue_drained", 128'(qsize(sel)), 128'(0));
        if (timing) chk("done_latency", 128'(cyc), 128'(last_acc_of(sel) + 1));
        @(negedge clk);
        chk("done_one_cycle", 128'(done_w[sel]), 128'(0));
    endtask

    initial begin
        vec_t vecs[7];
        int   base;
        bit   reached;
        vecs[0] = '{0, 60, 60, 2, 0, 0, 48'hAABBCCDDEEFF, 48'h112233445566, 16'h0000, 2};
        vecs[1] = '{1, 60, 62, 4, 0, 0, 48'h020000000001, 48'h02000000000A, 16'h0800, 4};
        vecs[2] = '{1, 60, 62, 3, 5, 1, 48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 16'h88B5, 3};
        vecs[3] = '{1,  5,  3, 3, 0, 1, 48'h010203040506, 48'h0708090A0B0C, 16'h0D0E, 3};
        vecs[4] = '{0,  5,  3, 2, 2, 1, 48'h102030405060, 48'h708090A0B0C0, 16'hD0E0, 2};
        vecs[5] = '{0, 14, 16, 4, 3, 1, 48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h86DD, 4};
        vecs[6] = '{1, 100, 70, 2, 1, 0, 48'h001122334455, 48'h66778899AABB, 16'h0806, 2};

        // Reset state
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_tvalid", 128'(tvalid_w[s]), 128'(0));
            chk("rst_tlast", 128'(tlast_w[s]), 128'(0));
            chk("rst_busy", 128'(busy_w[s]), 128'(0));
            chk("rst_done", 128'(done_w[s]), 128'(0));
            chk("rst_pkt_count", 128'(cnt_w[s]), 128'(0));
        end
        chk("rst_tdata8", 128'(g_dut[1].bus.tdata), 128'(0));
        chk("rst_tkeep8", 128'(g_dut[1].bus.tkeep), 128'(0));
        aresetn = 1'b1;
        @(negedge clk);

        // Table-driven runs
        for (int v = 0; v < 7; v++) begin
            set_cfg(vecs[v].min_len, vecs[v].max_len, vecs[v].num, vecs[v].gap,
                    vecs[v].dst, vecs[v].src, vecs[v].et);
            ready_mode = vecs[v].rmode;
            push_frames(vecs[v].sel, vecs[v].min_len, vecs[v].max_len, 0, vecs[v].num,
                        vecs[v].dst, vecs[v].src, vecs[v].et);
            pulse_start(vecs[v].sel);
            if (v == 1) begin
                // A start while busy must not restart the run.
                repeat (2) @(negedge clk);
                start_v[1] = 1'b1;
                @(negedge clk);
                start_v[1] = 1'b0;
            end
            wait_done(vecs[v].sel, 5000);
            end_checks(vecs[v].sel, vecs[v].exp_cnt, 1'b1);
            ready_mode = 0;
            $display("run %0d sel=%0d len=%0d..%0d num=%0d gap=%0d pkt_count=%0d",
                     v, vecs[v].sel, vecs[v].min_len, vecs[v].max_len, vecs[v].num,
                     vecs[v].gap, cnt_w[vecs[v].sel]);
        end

        // Indefinite stall keeps busy and the beat valid
        set_cfg(60, 62, 3, 0, 48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 16'h1234);
        push_frames(1, 60, 62, 0, 3, 48'h0A0A0A0A0A0A, 48'h0B0B0B0B0B0B, 16'h1234);
        pulse_start(1);
        repeat (3) @(negedge clk);
        ready_mode = 2;
        repeat (100) @(negedge clk);
        chk("stall_busy", 128'(busy_w[1]), 128'(1));
        chk("stall_tvalid", 128'(tvalid_w[1]), 128'(1));
        ready_mode = 0;
        wait_done(1, 2000);
        end_checks(1, 3, 1'b1);
        $display("stall run pkt_count=%0d", cnt_w[1]);

        // Unlimited run, stop mid-frame 3, then restart from frame 0
        set_cfg(60, 62, 0, 0, 48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800);
        push_frames(1, 60, 62, 0, 4, 48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800);
        base = frames_of(1);
        pulse_start(1);
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            if (frames_of(1) == base + 3) begin reached = 1; break; end
            @(negedge clk);
        end
        chk("reach_frame3", 128'(reached), 128'(1));
        repeat (2) @(negedge clk);
        pulse_stop();
        wait_done(1, 2000);
        end_checks(1, 4, 1'b1);
        $display("stop mid-frame pkt_count=%0d", cnt_w[1]);
        cfg_num_pkts = 16'd2;
        push_frames(1, 60, 62, 0, 2, 48'hAABBCCDDEEFF, 48'h112233445566, 16'h0800);
        pulse_start(1);
        wait_done(1, 2000);
        end_checks(1, 2, 1'b1);
        $display("restart after stop pkt_count=%0d", cnt_w[1]);

        // Stop during the gap ends the run at once
        set_cfg(14, 14, 0, 20, 48'h0102030405AA, 48'h0102030405BB, 16'hABCD);
        push_frames(0, 14, 14, 0, 1, 48'h0102030405AA, 48'h0102030405BB, 16'hABCD);
        base = frames_of(0);
        pulse_start(0);
        reached = 0;
        for (int c = 0; c < 500; c++) begin
            if (frames_of(0) == base + 1) begin reached = 1; break; end
            @(negedge clk);
        end
        chk("reach_gap", 128'(reached), 128'(1));
        repeat (3) @(negedge clk);
        pulse_stop();
        chk("done_on_gap_stop", 128'(done_w[0]), 128'(1));
        end_checks(0, 1, 1'b0);
        repeat (30) @(negedge clk);
        chk("no_frame_after_gap_stop", 128'(tvalid_w[0]), 128'(0));
        $display("stop in gap pkt_count=%0d", cnt_w[0]);

        // Asynchronous reset mid-frame
        set_cfg(60, 62, 0, 0, 48'h111111111111, 48'h222222222222, 16'h3333);
        push_frames(1, 60, 62, 0, 10, 48'h111111111111, 48'h222222222222, 16'h3333);
        pulse_start(1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 aresetn = 1'b0;
        #1;
        chk("arst_tvalid", 128'(tvalid_w[1]), 128'(0));
        chk("arst_tlast", 128'(tlast_w[1]), 128'(0));
        chk("arst_busy", 128'(busy_w[1]), 128'(0));
        g_dut[1].exp_q.delete();
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_tvalid", 128'(tvalid_w[1]), 128'(0));
        chk("post_rst_busy", 128'(busy_w[1]), 128'(0));
        chk("post_rst_pkt_count", 128'(cnt_w[1]), 128'(0));
        cfg_num_pkts = 16'd1;
        push_frames(1, 60, 62, 0, 1, 48'h111111111111, 48'h222222222222, 16'h3333);
        pulse_start(1);
        wait_done(1, 2000);
        end_checks(1, 1, 1'b1);
        $display("run after reset pkt_count=%0d", cnt_w[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
